// File: rtl/tdm_demux_1_2_pkg.sv
// Shared types and defaults for the two-channel TDM demultiplexer.
package tdm_demux_1_2_pkg;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_WAIT2  = 2'd1,
        S_LOCKED = 2'd2
    } tdm_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/tdm_frame_timer.sv
// Idle-cycle timer: expires on the LIMIT-th consecutive run cycle.
module tdm_frame_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Combinational so the FSM can act on the same edge that counts the last idle cycle.
    assign expire = run && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1_2.sv
// Two-channel TDM demultiplexer with frame alignment, timeout and frame counter.
module tdm_demux_1_2
    import tdm_demux_1_2_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic              out_1_valid,
    output logic              out_2_valid,
    output logic              pair_valid,
    output logic              err_sync,
    output logic [CNT_W-1:0]  frame_cnt
);

    tdm_state_t state_q, state_d;

    logic [DATA_W-1:0] out_1_d, out_2_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              v1_d, v2_d, err_d;
    logic              tmr_clear, tmr_run, tmr_expire;

    assign tmr_clear = in_valid || (state_q != S_WAIT2);
    assign tmr_run   = (state_q == S_WAIT2) && !in_valid;

    tdm_frame_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clear  (tmr_clear),
        .run    (tmr_run),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        out_1_d = out_1;
        out_2_d = out_2;
        cnt_d   = frame_cnt;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_WAIT2: begin
                if (in_valid && !in_sof) begin
                    out_2_d = in_data;
                    v2_d    = 1'b1;
                    cnt_d   = frame_cnt + 1'b1;
                    state_d = S_LOCKED;
                end else if (in_valid) begin
                    // A new sof restarts the frame rather than dropping it.
                    out_1_d = in_data;
                    v1_d    = 1'b1;
                    err_d   = 1'b1;
                end else if (tmr_expire) begin
                    err_d   = 1'b1;
                    state_d = S_HUNT;
                end
            end
            S_LOCKED: begin
                if (in_valid && in_sof) begin
                    out_1_d = in_data;
                    v1_d    = 1'b1;
                    state_d = S_WAIT2;
                end else if (in_valid) begin
                    err_d   = 1'b1;
                    state_d = S_HUNT;
                end
            end
            default: begin
                if (in_valid && in_sof) begin
                    out_1_d = in_data;
                    v1_d    = 1'b1;
                    state_d = S_WAIT2;
                end else if (in_valid) begin
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_HUNT;
            out_1       <= '0;
            out_2       <= '0;
            out_1_valid <= 1'b0;
            out_2_valid <= 1'b0;
            pair_valid  <= 1'b0;
            err_sync    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            out_1       <= out_1_d;
            out_2       <= out_2_d;
            out_1_valid <= v1_d;
            out_2_valid <= v2_d;
            pair_valid  <= v2_d;
            err_sync    <= err_d;
            frame_cnt   <= cnt_d;
        end
    end

endmodule
